// File: rtl/result_ram_writer_if.sv
// Pixel write port, byte readout stream and control for result_ram_writer.
// oOnesCount exists only when RESULT_ONES_COUNT_EN is defined.
interface result_ram_writer_if #(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8
);
   logic [WIDTH_BITS-1:0]  iResultCol;
   logic [HEIGHT_BITS-1:0] iResultRow;
   logic                   iResultData;
   logic                   iResultWren;
   logic                   iFinished;
   logic [7:0]             oData;
   logic                   oValid;
   logic                   iReady;
   logic                   oLast;
   logic                   oDone;
   logic                   oOverrun;
   logic                   iRestart;
`ifdef RESULT_ONES_COUNT_EN
   logic [WIDTH_BITS+HEIGHT_BITS:0] oOnesCount;
`endif

   modport master (
`ifdef RESULT_ONES_COUNT_EN
      input  oOnesCount,
`endif
      output iResultCol, iResultRow, iResultData, iResultWren, iFinished,
      output iReady, iRestart,
      input  oData, oValid, oLast, oDone, oOverrun
   );

   modport slave (
`ifdef RESULT_ONES_COUNT_EN
      output oOnesCount,
`endif
      input  iResultCol, iResultRow, iResultData, iResultWren, iFinished,
      input  iReady, iRestart,
      output oData, oValid, oLast, oDone, oOverrun
   );
endinterface

// File: rtl/result_ram_writer.sv
// Captures a binarised frame into eight 1-bit banks, then streams it out as packed bytes
// (first byte 2 cycles after DRAIN entry, iReady backpressure, no bubbles). Optional RESULT_ONES_COUNT_EN.
module result_ram_writer #(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8
) (
   input logic              clock,
   input logic              reset,
   result_ram_writer_if.slave bus
);
   localparam int ADDR_BITS = WIDTH_BITS - 3 + HEIGHT_BITS;
   localparam int CNT_BITS  = WIDTH_BITS + HEIGHT_BITS + 1;
   localparam int DEPTH     = 1 << ADDR_BITS;
   localparam logic [CNT_BITS-1:0]  TOTAL_M1  = {1'b0, {(CNT_BITS-1){1'b1}}};
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      S_CAPTURE = 2'd0,
      S_DRAIN   = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                r_state, w_next;
   logic [CNT_BITS-1:0]   r_count;
   logic [ADDR_BITS-1:0]  r_rd_addr;
   logic                  r_rd_all;
   logic                  r_p_vld, r_p_last;
   logic [7:0]            r_data;
   logic                  r_valid, r_last, r_overrun;
   logic [7:0]            w_rd_byte;
   logic [ADDR_BITS-1:0]  w_wr_addr;
   logic                  w_wr_en, w_full, w_adv, w_issue, w_last_hs, w_enter_drain;

   assign w_wr_addr     = {bus.iResultRow, bus.iResultCol[WIDTH_BITS-1:3]};
   assign w_wr_en       = (r_state == S_CAPTURE) && bus.iResultWren;
   assign w_full        = w_wr_en && (r_count == TOTAL_M1);
   assign w_adv         = !r_valid || bus.iReady;
   // Read only into an empty prefetch slot, or one being emptied this cycle.
   assign w_issue       = (r_state == S_DRAIN) && !r_rd_all && (!r_p_vld || w_adv);
   assign w_last_hs     = r_valid && bus.iReady && r_last;
   assign w_enter_drain = (r_state == S_CAPTURE) && (w_next == S_DRAIN);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CAPTURE: if (bus.iFinished || w_full) w_next = S_DRAIN;
         S_DRAIN:   if (w_last_hs)               w_next = S_DONE;
         S_DONE:    if (bus.iRestart)            w_next = S_CAPTURE;
         default:                                w_next = S_CAPTURE;
      endcase
   end

   for (genvar g = 0; g < 8; g++) begin : g_bank
      logic r_mem [DEPTH];
      logic r_q;
      always_ff @(posedge clock) begin
         if (w_wr_en && (bus.iResultCol[2:0] == 3'(g))) r_mem[w_wr_addr] <= bus.iResultData;
         if (w_issue) r_q <= r_mem[r_rd_addr];
      end
      assign w_rd_byte[7-g] = r_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_CAPTURE;
         r_count   <= '0;
         r_rd_addr <= '0;
         r_rd_all  <= 1'b0;
         r_p_vld   <= 1'b0;
         r_p_last  <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_next;
         if (bus.iResultWren && (r_state != S_CAPTURE)) r_overrun <= 1'b1;
         if (r_state == S_DRAIN) begin
            if (w_issue) begin
               r_rd_addr <= r_rd_addr + 1'b1;
               r_rd_all  <= (r_rd_addr == LAST_ADDR);
               r_p_last  <= (r_rd_addr == LAST_ADDR);
               r_p_vld   <= 1'b1;
            end else if (w_adv) begin
               r_p_vld   <= 1'b0;
            end
            if (w_adv) begin
               r_valid <= r_p_vld;
               r_last  <= r_p_vld && r_p_last;
               if (r_p_vld) r_data <= w_rd_byte;
            end
         end else begin
            if (r_state == S_CAPTURE && w_wr_en) r_count <= r_count + 1'b1;
            if (r_state == S_DONE && bus.iRestart) r_count <= '0;
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
            r_p_vld   <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
         end
      end
   end

   assign bus.oData    = r_data;
   assign bus.oValid   = r_valid;
   assign bus.oLast    = r_last;
   assign bus.oDone    = (r_state == S_DONE);
   assign bus.oOverrun = r_overrun;

`ifdef RESULT_ONES_COUNT_EN
   logic [CNT_BITS-1:0] r_ones;
   logic [3:0]          w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < 8; i++) w_pop = w_pop + {3'd0, r_data[i]};
   end

   always_ff @(posedge clock) begin
      if (reset || w_enter_drain)
         r_ones <= '0;
      else if (r_state == S_DRAIN && r_valid && bus.iReady)
         r_ones <= r_ones + CNT_BITS'(w_pop);
   end

   assign bus.oOnesCount = r_ones;
`endif
endmodule

// File: tb/tb_result_ram_writer.sv
// Bench for result_ram_writer on a reduced 64x32 frame: table of whole-frame scenarios
// checked against a pixel-array model, plus early-finish, overrun and reset-in-drain sequences.
module tb_result_ram_writer;
   localparam int WB     = 6;
   localparam int HB     = 5;
   localparam int W      = 1 << WB;
   localparam int H      = 1 << HB;
   localparam int NPIX   = W * H;
   localparam int NBYTES = NPIX / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   result_ram_writer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus();
   result_ram_writer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   bit model [H][W];

   typedef struct {
      int pattern;   // 0 col[0], 1 checkerboard, 2 zeros, 3 ones, 4 random
      int rdy_pct;
      bit noise;     // toggle iRestart during drain (must be ignored)
      int exp_first; // -1: no constant expectation
      int exp_ones;  // -1: derive from model
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit pix(input int p, input int r, input int c);
      case (p)
         0:       return bit'(c & 1);
         1:       return bit'((r ^ c) & 1);
         2:       return 1'b0;
         3:       return 1'b1;
         default: return bit'($urandom_range(0, 1));
      endcase
   endfunction

   function automatic logic [7:0] exp_byte(input int a);
      logic [7:0] b;
      int r, cb;
      r  = a / (W / 8);
      cb = (a % (W / 8)) * 8;
      for (int k = 0; k < 8; k++) b[7-k] = model[r][cb+k];
      return b;
   endfunction

   function automatic int model_ones();
      int n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) n += int'(model[r][c]);
      return n;
   endfunction

   task automatic idle();
      bus.iResultCol  = '0;
      bus.iResultRow  = '0;
      bus.iResultData = 1'b0;
      bus.iResultWren = 1'b0;
      bus.iFinished   = 1'b0;
      bus.iReady      = 1'b0;
      bus.iRestart    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      check("reset_outputs", {bus.oValid, bus.oLast, bus.oDone, bus.oOverrun, bus.oData}, 32'd0);
      rst = 1'b0;
   endtask

   // Called just after the edge that enters DRAIN.
   task automatic check_entry(input int exp_first);
      bus.iReady = 1'b0;
      check("entry_e0_valid", bus.oValid, 0);
      cyc();
      check("entry_e1_valid", bus.oValid, 0);
      cyc();
      check("entry_e2_valid", bus.oValid, 1);
      if (exp_first >= 0) check("first_byte", bus.oData, exp_first);
   endtask

   task automatic write_frame(input int p, input int exp_first);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            bus.iResultWren = 1'b1;
            bus.iResultRow  = HB'(r);
            bus.iResultCol  = WB'(c);
            bus.iResultData = pix(p, r, c);
            model[r][c]     = bus.iResultData;
            cyc();
         end
      end
      bus.iResultWren = 1'b0;
      check_entry(exp_first);
   endtask

   task automatic drain(input int first, input int stop, input int rdy_pct,
                        input int inject_cyc, input bit noise);
      int         idx    = first;
      int         cycles = 0;
      logic [7:0] sd;
      logic       sl, sv;
      while (idx < stop && cycles < 40 * NBYTES + 100) begin
         sv = bus.oValid;
         sd = bus.oData;
         sl = bus.oLast;
         bus.iReady      = ($urandom_range(1, 100) <= rdy_pct);
         bus.iResultWren = (cycles == inject_cyc);
         bus.iResultRow  = HB'(H - 1);
         bus.iResultCol  = WB'(W - 1);
         bus.iResultData = !model[H-1][W-1];
         if (noise) bus.iRestart = 1'($urandom_range(0, 1));
         cyc();
         cycles++;
         if (sv && bus.iReady) begin
            check("drain_data", sd, exp_byte(idx));
            check("drain_last", sl, (idx == NBYTES - 1) ? 1 : 0);
            idx++;
         end else if (sv) begin
            check("stall_hold", {bus.oValid, bus.oLast, bus.oData}, {1'b1, sl, sd});
         end
      end
      bus.iReady      = 1'b0;
      bus.iResultWren = 1'b0;
      bus.iRestart    = 1'b0;
      if (idx < stop) check("drain_timeout", idx, stop);
   endtask

   task automatic done_check(input int exp_ones);
      check("done_flag", {bus.oDone, bus.oValid}, 2'b10);
`ifdef RESULT_ONES_COUNT_EN
      check("ones_count", bus.oOnesCount, (exp_ones >= 0) ? exp_ones : model_ones());
`else
      if (exp_ones < -1) check("ones_unused", exp_ones, -1);
`endif
   endtask

   task automatic restart();
      check("pre_restart_done", bus.oDone, 1);
      bus.iRestart = 1'b1;
      cyc();
      bus.iRestart = 1'b0;
      check("post_restart_done", bus.oDone, 0);
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = '{0, 100, 1'b0, 'h55, NPIX / 2};
      vecs[1] = '{1,  45, 1'b0, 'h55, NPIX / 2};
      vecs[2] = '{4,  70, 1'b1,   -1,       -1};
      vecs[3] = '{3, 100, 1'b0, 'hFF,     NPIX};
      vecs[4] = '{2, 100, 1'b0, 'h00,        0};

      rst = 1'b1;
      idle();
      do_reset();

      for (int i = 0; i < 5; i++) begin
         if (i > 0) restart();
         write_frame(vecs[i].pattern, vecs[i].exp_first);
         drain(0, NBYTES, vecs[i].rdy_pct, -1, vecs[i].noise);
         done_check(vecs[i].exp_ones);
      end

      // Early finish: 10 ones on row 0 over a zero frame; iFinished with the last strobe.
      restart();
      for (int c = 0; c < 10; c++) begin
         bus.iResultWren = 1'b1;
         bus.iResultRow  = '0;
         bus.iResultCol  = WB'(c);
         bus.iResultData = 1'b1;
         bus.iFinished   = (c == 9);
         model[0][c]     = 1'b1;
         cyc();
      end
      bus.iResultWren = 1'b0;
      bus.iFinished   = 1'b0;
      check_entry('hFF);
      drain(0, 1, 100, -1, 1'b0);
      check("early_second", {bus.oValid, bus.oData}, {1'b1, 8'hC0});
      drain(1, NBYTES, 100, -1, 1'b0);
      done_check(10);

      // Overrun: strobe during DRAIN is ignored and sticks until reset.
      restart();
      bus.iFinished = 1'b1;
      cyc();
      bus.iFinished = 1'b0;
      check_entry(-1);
      check("overrun_before", bus.oOverrun, 0);
      drain(0, NBYTES, 80, 5, 1'b0);
      check("overrun_set", bus.oOverrun, 1);
      done_check(-1);
      restart();
      check("overrun_after_restart", bus.oOverrun, 1);
      do_reset();

      // Reset with a byte pending mid-drain, then a fresh frame.
      write_frame(4, -1);
      drain(0, 100, 100, -1, 1'b0);
      check("pending_before_reset", bus.oValid, 1);
      rst = 1'b1;
      cyc();
      check("reset_mid_drain", {bus.oValid, bus.oLast, bus.oDone, bus.oData}, 32'd0);
      rst = 1'b0;
      write_frame(1, 'h55);
      drain(0, NBYTES, 60, -1, 1'b0);
      done_check(NPIX / 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
